// File: rtl/add_arb_pkg.sv
// add_arb_pkg
//   Shared types and defaults for the add_pipe_arbiter slice.
//   - calc_id_w : width of a requester index for a given requester count
//   - tag_t     : one stage of the result-ownership pipeline {valid, id}
//   The tag id field is sized for the largest supported requester count (16),
//   so narrower configurations zero-extend into it.
package add_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int LATENCY_DEF = 2;
    localparam int MAX_ID_W    = 4;

    function automatic int calc_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: the first set bit of req at or
//   after ptr, wrapping modulo N.
//   Ports:
//     req     in  N     request vector
//     ptr     in  ID_W  search start index
//     gnt     out N     one-hot-or-zero grant
//     gnt_id  out ID_W  encoded index of gnt (0 when no grant)
//     gnt_any out 1     a grant was made
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    always_comb begin
        logic [ID_W-1:0] idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/add_pipe_arbiter.sv
// add_pipe_arbiter
//   Shares one registered-in/registered-out adder among NUM_REQ requesters.
//   One operand pair is granted per cycle (round robin), steered onto
//   add_x/add_y, and its owner id travels down a LATENCY-deep tag pipeline so
//   that resp_valid/resp_id line up with the sum on add_out.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     en                  gate for new grants (in-flight ops still complete)
//     req_valid/req_ready per-requester handshake (ready is one-hot-or-zero)
//     req_x/req_y         packed operands, requester i at [i*DATA_W +: DATA_W]
//     add_x/add_y         operands to the adder (0 when nothing is granted)
//     add_out             adder result
//     resp_valid/id/data  result and its owner
//     idle                no operation in flight
//     stat_grants/busy    only with ADD_ARB_STATS_EN: per-requester grant
//                         counters and busy-cycle counter, 32-bit wrapping
module add_pipe_arbiter
    import add_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int LATENCY = LATENCY_DEF,
    localparam int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    output logic [DATA_W-1:0]         add_x,
    output logic [DATA_W-1:0]         add_y,
    input  logic [DATA_W-1:0]         add_out,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
`ifdef ADD_ARB_STATS_EN
    output logic [NUM_REQ*32-1:0]     stat_grants,
    output logic [31:0]               stat_busy,
`endif
    output logic                      idle
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    tag_t               tag_q [LATENCY];
    tag_t               tag_d [LATENCY];

    // Masking with rst keeps ready low during reset without a registered
    // gate, so a grant can never be issued into a pipeline being cleared.
    assign arb_req = (en && !rst) ? req_valid : '0;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;

    // One-hot select; all-zero grant leaves the adder inputs at 0.
    always_comb begin
        add_x = '0;
        add_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                add_x = req_x[i*DATA_W +: DATA_W];
                add_y = req_y[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any)
            rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end

    always_comb begin
        tag_d[0].valid = gnt_any;
        tag_d[0].id    = MAX_ID_W'(gnt_id);
        for (int i = 1; i < LATENCY; i++)
            tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < LATENCY; i++)
                tag_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < LATENCY; i++)
                tag_q[i] <= tag_d[i];
        end
    end

    assign resp_valid = tag_q[LATENCY-1].valid;
    assign resp_id    = tag_q[LATENCY-1].id[ID_W-1:0];
    assign resp_data  = add_out;

    always_comb begin
        idle = 1'b1;
        for (int i = 0; i < LATENCY; i++)
            if (tag_q[i].valid)
                idle = 1'b0;
    end

`ifdef ADD_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grants_q, grants_d;
    logic [31:0]              busy_q, busy_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            grants_d[i] = grants_q[i] + {31'b0, gnt[i]};
        busy_d = busy_q + {31'b0, ~idle};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grants_q <= '0;
            busy_q   <= '0;
        end else begin
            grants_q <= grants_d;
            busy_q   <= busy_d;
        end
    end

    assign stat_grants = grants_q;
    assign stat_busy   = busy_q;
`else
    // Statistics build option off: no counters are instantiated.
`endif

endmodule

// File: tb/tb_add_pipe_arbiter.sv
module tb_add_pipe_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst, en;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_x, req_y;
    logic [W-1:0]   add_x, add_y, add_out;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_data;
    logic           idle;
`ifdef ADD_ARB_STATS_EN
    logic [N*32-1:0] stat_grants;
    logic [31:0]     stat_busy;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Environment model of the adder: input register then output register.
    logic [W-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= add_x + add_y;
        a2 <= a1;
    end
    assign add_out = a2;

    add_pipe_arbiter #(.NUM_REQ(N), .DATA_W(W), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .add_x      (add_x),
        .add_y      (add_y),
        .add_out    (add_out),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
`ifdef ADD_ARB_STATS_EN
        .stat_grants(stat_grants),
        .stat_busy  (stat_busy),
`endif
        .idle       (idle)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b1; req_valid = '0; req_x = '0; req_y = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; req_valid = 4'b1111;
        req_x = {N{32'd7}}; req_y = {N{32'd9}};
        next_cycle; next_cycle;
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) $display("FAIL rst_ready act=%b exp=0000", req_ready); else passed++;
        total++; if (add_x !== 32'd0) $display("FAIL rst_add_x act=%h exp=0", add_x); else passed++;
        total++; if (add_y !== 32'd0) $display("FAIL rst_add_y act=%h exp=0", add_y); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid act=%b exp=0", resp_valid); else passed++;
        total++; if (resp_id !== 2'd0) $display("FAIL rst_resp_id act=%0d exp=0", resp_id); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL rst_idle act=%b exp=1", idle); else passed++;
        next_cycle;
        rst = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
    endtask

    task automatic test_single;
        req_valid = 4'b0001; req_x[0 +: W] = 32'd5; req_y[0 +: W] = 32'd7;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) $display("FAIL single_ready act=%b exp=0001", req_ready); else passed++;
        total++; if (add_x !== 32'd5 || add_y !== 32'd7) $display("FAIL single_ops act=%0d,%0d exp=5,7", add_x, add_y); else passed++;
        next_cycle; req_valid = '0;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || idle !== 1'b0) $display("FAIL single_c1 act=v%b idle%b exp=v0 idle0", resp_valid, idle); else passed++;
        next_cycle;
        @(negedge clk);
        total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'd12)
            $display("FAIL single_resp act=v%b id%0d d%0d exp=v1 id0 d12", resp_valid, resp_id, resp_data); else passed++;
        next_cycle;
        @(negedge clk);
        total++; if (idle !== 1'b1 || resp_valid !== 1'b0) $display("FAIL single_idle act=idle%b v%b exp=idle1 v0", idle, resp_valid); else passed++;
    endtask

    task automatic test_all_valid;
        logic [N-1:0] er;
        do_reset;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = 32'(i);
            req_y[i*W +: W] = 32'd100;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = '0;
            er = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            @(negedge clk);
            total++; if (req_ready !== er) $display("FAIL rr_ready c=%0d act=%b exp=%b", c, req_ready, er); else passed++;
            if (c >= 2) begin
                total++;
                if (resp_valid !== 1'b1 || resp_id !== 2'((c-2) % 4) || resp_data !== 32'(100 + (c-2) % 4))
                    $display("FAIL rr_resp c=%0d act=v%b id%0d d%0d exp=v1 id%0d d%0d",
                             c, resp_valid, resp_id, resp_data, (c-2) % 4, 100 + (c-2) % 4);
                else passed++;
            end
            next_cycle;
        end
        @(negedge clk);
        total++; if (idle !== 1'b1) $display("FAIL rr_idle act=%b exp=1", idle); else passed++;
    endtask

    task automatic test_wrap;
        do_reset;
        req_x[2*W +: W] = 32'hFFFF_FFFF; req_y[2*W +: W] = 32'd2; req_valid = 4'b0100;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) $display("FAIL wrap_ready act=%b exp=0100", req_ready); else passed++;
        next_cycle; req_valid = '0;
        next_cycle;
        @(negedge clk);
        total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 32'd1)
            $display("FAIL wrap_resp act=v%b id%0d d%h exp=v1 id2 d1", resp_valid, resp_id, resp_data); else passed++;
        next_cycle;
    endtask

    task automatic test_enable;
        do_reset;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = 32'(i);
            req_y[i*W +: W] = 32'd10;
        end
        req_valid = 4'b1111;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) $display("FAIL en_first act=%b exp=0001", req_ready); else passed++;
        next_cycle; en = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b0000 || add_x !== 32'd0) $display("FAIL en_low act=%b x%0d exp=0000 x0", req_ready, add_x); else passed++;
        next_cycle;
        @(negedge clk);
        total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'd10 || req_ready !== 4'b0000)
            $display("FAIL en_inflight act=v%b id%0d d%0d r%b exp=v1 id0 d10 r0000", resp_valid, resp_id, resp_data, req_ready); else passed++;
        next_cycle;
        @(negedge clk);
        total++; if (idle !== 1'b1 || resp_valid !== 1'b0) $display("FAIL en_idle act=idle%b v%b exp=idle1 v0", idle, resp_valid); else passed++;
        next_cycle; en = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010 || add_x !== 32'd1) $display("FAIL en_resume act=%b x%0d exp=0010 x1", req_ready, add_x); else passed++;
        next_cycle; req_valid = '0;
        next_cycle;
        @(negedge clk);
        total++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'd11)
            $display("FAIL en_resume_resp act=v%b id%0d d%0d exp=v1 id1 d11", resp_valid, resp_id, resp_data); else passed++;
        next_cycle;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_x[2*W +: W] = 32'd3;  req_y[2*W +: W] = 32'd4;
        req_x[1*W +: W] = 32'd20; req_y[1*W +: W] = 32'd22;
        req_x[3*W +: W] = 32'd50; req_y[3*W +: W] = 32'd50;
        req_valid = 4'b0100;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) $display("FAIL rmid_grant act=%b exp=0100", req_ready); else passed++;
        next_cycle; rst = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) $display("FAIL rmid_rst_ready act=%b exp=0000", req_ready); else passed++;
        next_cycle; rst = 1'b0; req_valid = 4'b1010;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) $display("FAIL rmid_dropped act=%b exp=0", resp_valid); else passed++;
        total++; if (req_ready !== 4'b0010) $display("FAIL rmid_ptr act=%b exp=0010", req_ready); else passed++;
        next_cycle; req_valid = '0;
        next_cycle;
        @(negedge clk);
        total++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'd42)
            $display("FAIL rmid_resp act=v%b id%0d d%0d exp=v1 id1 d42", resp_valid, resp_id, resp_data); else passed++;
        next_cycle;
    endtask

    task automatic test_single_requester;
        do_reset;
        req_x[3*W +: W] = 32'd1; req_y[3*W +: W] = 32'd2;
        req_valid = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (req_ready !== 4'b1000) $display("FAIL lone_ready c=%0d act=%b exp=1000", c, req_ready); else passed++;
            next_cycle;
        end
        req_valid = '0;
        next_cycle; next_cycle;
    endtask

`ifdef ADD_ARB_STATS_EN
    task automatic test_stats;
        do_reset;
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) next_cycle;
        req_valid = '0;
        for (int c = 0; c < 3; c++) next_cycle;
        @(negedge clk);
        total++; if (stat_grants[1*32 +: 32] !== 32'd5) $display("FAIL stat_grants act=%0d exp=5", stat_grants[1*32 +: 32]); else passed++;
        total++; if (stat_busy !== 32'd6) $display("FAIL stat_busy act=%0d exp=6", stat_busy); else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
        test_reset;
        test_single;
        test_all_valid;
        test_wrap;
        test_enable;
        test_reset_mid;
        test_single_requester;
`ifdef ADD_ARB_STATS_EN
        test_stats;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
